reg32_byte_store: RTL and testbench
===================================

# reg32_byte_store

Store-side counterpart of the 32-bit register's byte-load path: takes a 32-bit register value and writes it to byte-wide memory, one byte per handshake beat, most significant byte of the selected width first. It sits between the register file/ALU output and the 8-bit memory port, so a multi-byte value shifted in a byte at a time can be written back in the same byte order.

## Interface
- ADDR_WIDTH, 16, width of memory byte address
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request a store; sampled only when Busy=0
- Size  input  2  00=1 byte (Data[7:0]), 01=2 bytes (Data[15:0]), 10/11=4 bytes (Data[31:0])
- Data  input  32  value to store; latched on accepted Start
- Addr  input  ADDR_WIDTH  base byte address; latched on accepted Start
- MemAck  input  1  memory accepts current beat this cycle
- MemWR  output  1  write request, valid beat present
- MemAddr  output  ADDR_WIDTH  byte address of current beat
- MemData  output  8  byte of current beat
- Busy  output  1  transfer in progress
- Done  output  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: MemWR=0, Busy=0. Start=1 -> latch Data, Addr, beat count N (1/2/4), beat index=0; go WRITE.
- WRITE: Busy=1, MemWR=1. MemData = byte (N-1-index) of latched Data (big-endian: MSB of selected width first). MemAddr = latched Addr + index.
- Beat accepted when MemWR=1 and MemAck=1 at a rising edge. Accepted: index+1; if index was N-1 -> DONE. Not accepted: MemAddr/MemData/MemWR held unchanged (no retraction).
- DONE: Done=1, Busy=0, MemWR=0 for exactly one cycle. Start=1 in DONE accepted as in IDLE (back-to-back) -> WRITE; else -> IDLE.
- Start while Busy=1 ignored; Data/Addr/Size changes during transfer have no effect.
- Address arithmetic modulo 2^ADDR_WIDTH: base 0xFFFF with 4 bytes writes FFFF, 0000, 0001, 0002.
- Size=11 treated exactly as 10.
- Reset (any state, including mid-transfer): -> IDLE; MemWR=0, MemAddr=0, MemData=0, Busy=0, Done=0; internal latches cleared; partially written bytes are not undone.

## Timing
- All outputs registered; reset values all 0.
- Start accepted at edge k -> first beat (MemWR=1) visible in cycle k+1.
- Zero-wait memory (MemAck tied 1): N beats in cycles k+1..k+N, Done in k+N+1; next Start in that cycle puts its first beat in k+N+2.
- Each cycle of MemAck=0 in WRITE adds one cycle; no beat is skipped or duplicated.
- MemAck ignored when MemWR=0.
- Reset and Start both high: Reset wins.

## Test plan
- Reset mid-transfer: Size=10, after 2 accepted beats assert Reset -> next cycle MemWR=0, Busy=0, Done=0, MemAddr=0; no further beats.
- 4-byte, zero wait: Data=0x11223344, Addr=0x0100, MemAck=1 -> beats (0x0100,0x11),(0x0101,0x22),(0x0102,0x33),(0x0103,0x44) on consecutive cycles, Done pulse one cycle later.
- 2-byte with stalls: Data=0xDEADBEEF, Size=01, Addr=0x0020, MemAck low 3 cycles on first beat -> (0x0020,0xBE) held 4 cycles, then (0x0021,0xEF), Done.
- 1-byte and Size=11: Size=00 Data=0x000000A5 -> single beat 0xA5; Size=11 Data=0xCAFEF00D -> CA,FE,F0,0D.
- Wrap and back-to-back: Addr=0xFFFE, Size=10 -> addresses FFFE,FFFF,0000,0001; Start held high in Done cycle with Addr=0x0040, Size=00 -> its beat appears the next cycle.
- Ignored Start: Start pulsed with Data=0x55 during a busy transfer -> current beats unchanged, no extra transfer, single Done.

Source files
------------

// File: rtl/reg32_byte_store.sv
// Writes a 1/2/4-byte register value to a byte-wide memory port, one beat per
// accepted handshake, most significant byte of the selected width first.
module reg32_byte_store #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [1:0]            size_i,
   input  logic [31:0]           data_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  mem_ack_i,
   output logic                  mem_wr_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [7:0]            mem_data_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [31:0]           shift_q, shift_d;
   logic [1:0]            left_q, left_d;
   logic                  mem_wr_q, mem_wr_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]            mem_data_q, mem_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // The selected bytes are left-aligned so the current beat is always [31:24].
   logic [31:0] aligned;
   logic [1:0]  beats_m1;

   always_comb begin
      case (size_i)
         2'b00:   begin aligned = {data_i[7:0], 24'h0};  beats_m1 = 2'd0; end
         2'b01:   begin aligned = {data_i[15:0], 16'h0}; beats_m1 = 2'd1; end
         default: begin aligned = data_i;                beats_m1 = 2'd3; end
      endcase
   end

   // NOTE: every signal gets its default before the case; a path that skips an
   // assignment in always_comb would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      left_d     = left_q;
      mem_wr_d   = mem_wr_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         S_WRITE: begin
            if (mem_wr_q && mem_ack_i) begin
               if (left_q == 2'd0) begin
                  state_d  = S_DONE;
                  mem_wr_d = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  shift_d    = shift_q << 8;
                  left_d     = left_q - 2'd1;
                  mem_addr_d = mem_addr_q + 1'b1;
                  mem_data_d = shift_q[23:16];
               end
            end
         end
         default: begin
            // IDLE and DONE accept a new request identically (back-to-back).
            state_d  = S_IDLE;
            mem_wr_d = 1'b0;
            busy_d   = 1'b0;
            if (start_i) begin
               state_d    = S_WRITE;
               shift_d    = aligned;
               left_d     = beats_m1;
               mem_wr_d   = 1'b1;
               busy_d     = 1'b1;
               mem_addr_d = addr_i;
               mem_data_d = aligned[31:24];
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         left_q     <= '0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         left_q     <= left_d;
         mem_wr_q   <= mem_wr_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign mem_wr_o   = mem_wr_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_data_o = mem_data_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_reg32_byte_store.sv
// Self-checking bench: each store is expanded into its expected (address, byte)
// beat list and the DUT's beat stream is matched against it cycle by cycle.
module tb_reg32_byte_store;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset_i, start_i, mem_ack_i;
   logic [1:0]    size_i;
   logic [31:0]   data_i;
   logic [AW-1:0] addr_i;
   logic          mem_wr_o, busy_o, done_o;
   logic [AW-1:0] mem_addr_o;
   logic [7:0]    mem_data_o;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } beat_t;

   always #5 clk = ~clk;

   reg32_byte_store #(.ADDR_WIDTH(AW)) dut (
      .clock_i   (clk),
      .reset_i   (reset_i),
      .start_i   (start_i),
      .size_i    (size_i),
      .data_i    (data_i),
      .addr_i    (addr_i),
      .mem_ack_i (mem_ack_i),
      .mem_wr_o  (mem_wr_o),
      .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   // Outputs are observed and inputs changed 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues a store starting at the next edge, then follows it to its Done
   // cycle; returns with the bench sitting in that Done cycle.
   task automatic run_store(input logic [31:0] d, input logic [1:0] sz,
                            input logic [AW-1:0] a, input int stall_first,
                            input bit rand_ack, input bit junk_start,
                            input string name);
      beat_t q[$];
      int    n;
      int    cyc   = 0;
      int    stall = stall_first;
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++)
         q.push_back('{addr: a + AW'(i), data: 8'(d >> (8 * (n - 1 - i)))});

      start_i   = 1'b1;
      data_i    = d;
      size_i    = sz;
      addr_i    = a;
      mem_ack_i = 1'($urandom_range(0, 1));
      step();
      while (q.size() > 0 && cyc < 100) begin
         chk_cnt++;
         if ({mem_wr_o, busy_o, done_o, mem_addr_o, mem_data_o} !== {3'b110, q[0].addr, q[0].data})
            $display("FAIL %s beat %0d: got wr=%b busy=%b done=%b addr=%h data=%h, want wr=1 busy=1 done=0 addr=%h data=%h",
                     name, n - q.size(), mem_wr_o, busy_o, done_o, mem_addr_o, mem_data_o,
                     q[0].addr, q[0].data);
         else
            pass_cnt++;
         if (stall > 0) begin
            mem_ack_i = 1'b0;
            stall--;
         end else begin
            mem_ack_i = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         start_i = junk_start ? 1'($urandom_range(0, 1)) : 1'b0;
         if (junk_start) begin
            data_i = (($urandom_range(0, 1) == 1) ? 32'h55 : $urandom);
            size_i = 2'($urandom);
            addr_i = AW'($urandom);
         end
         step();
         if (mem_ack_i) void'(q.pop_front());
         cyc++;
      end
      start_i   = 1'b0;
      mem_ack_i = 1'b0;
      if (q.size() > 0) begin
         chk_cnt++;
         $display("FAIL %s timeout: %0d beats outstanding, want 0", name, q.size());
      end
      chk_cnt++;
      if ({mem_wr_o, busy_o, done_o} !== 3'b001)
         $display("FAIL %s done: got wr=%b busy=%b done=%b, want wr=0 busy=0 done=1",
                  name, mem_wr_o, busy_o, done_o);
      else
         pass_cnt++;
   endtask

   task automatic expect_idle(input string name);
      step();
      chk_cnt++;
      if ({mem_wr_o, busy_o, done_o} !== 3'b000)
         $display("FAIL %s idle: got wr=%b busy=%b done=%b, want 000",
                  name, mem_wr_o, busy_o, done_o);
      else
         pass_cnt++;
   endtask

   task automatic test_reset();
      reset_i   = 1'b1;
      start_i   = 1'b1;
      mem_ack_i = 1'b1;
      size_i    = 2'b10;
      data_i    = 32'h12345678;
      addr_i    = 16'h1234;
      step();
      step();
      chk_cnt++;
      if ({mem_wr_o, busy_o, done_o, mem_addr_o, mem_data_o} !== '0)
         $display("FAIL reset: got wr=%b busy=%b done=%b addr=%h data=%h, want all 0",
                  mem_wr_o, busy_o, done_o, mem_addr_o, mem_data_o);
      else
         pass_cnt++;
      reset_i = 1'b0;
      start_i = 1'b0;
      expect_idle("reset");
   endtask

   task automatic test_four_byte_zero_wait();
      run_store(32'h11223344, 2'b10, 16'h0100, 0, 1'b0, 1'b0, "four_byte");
      expect_idle("four_byte");
   endtask

   task automatic test_two_byte_stall();
      run_store(32'hDEADBEEF, 2'b01, 16'h0020, 3, 1'b0, 1'b0, "two_byte_stall");
      expect_idle("two_byte_stall");
   endtask

   task automatic test_one_byte_and_size3();
      run_store(32'h000000A5, 2'b00, 16'h0300, 0, 1'b0, 1'b0, "one_byte");
      expect_idle("one_byte");
      run_store(32'hCAFEF00D, 2'b11, 16'h0400, 0, 1'b0, 1'b0, "size3");
      expect_idle("size3");
   endtask

   task automatic test_wrap_back_to_back();
      run_store(32'h01020304, 2'b10, 16'hFFFE, 0, 1'b0, 1'b0, "wrap");
      run_store(32'h9ABCDE77, 2'b00, 16'h0040, 0, 1'b0, 1'b0, "back_to_back");
      expect_idle("back_to_back");
   endtask

   task automatic test_ignored_start();
      run_store(32'hA1B2C3D4, 2'b10, 16'h0800, 1, 1'b1, 1'b1, "ignored_start");
      expect_idle("ignored_start");
   endtask

   task automatic test_reset_mid_transfer();
      start_i   = 1'b1;
      size_i    = 2'b10;
      data_i    = 32'h8899AABB;
      addr_i    = 16'h0500;
      mem_ack_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      step();
      chk_cnt++;
      if ({mem_wr_o, mem_addr_o, mem_data_o} !== {1'b1, 16'h0502, 8'hAA})
         $display("FAIL reset_mid third beat: got wr=%b addr=%h data=%h, want 1 0502 aa",
                  mem_wr_o, mem_addr_o, mem_data_o);
      else
         pass_cnt++;
      reset_i = 1'b1;
      start_i = 1'b1;
      step();
      chk_cnt++;
      if ({mem_wr_o, busy_o, done_o, mem_addr_o, mem_data_o} !== '0)
         $display("FAIL reset_mid: got wr=%b busy=%b done=%b addr=%h data=%h, want all 0",
                  mem_wr_o, busy_o, done_o, mem_addr_o, mem_data_o);
      else
         pass_cnt++;
      reset_i = 1'b0;
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) expect_idle("reset_mid_after");
   endtask

   task automatic test_random();
      for (int t = 0; t < 30; t++) begin
         run_store($urandom, 2'($urandom), AW'($urandom), $urandom_range(0, 2),
                   1'b1, 1'b1, "random");
         if ($urandom_range(0, 1) == 1) expect_idle("random");
      end
      expect_idle("random_end");
   endtask

   initial begin
      reset_i   = 1'b1;
      start_i   = 1'b0;
      mem_ack_i = 1'b0;
      size_i    = 2'b00;
      data_i    = '0;
      addr_i    = '0;
      test_reset();
      test_four_byte_zero_wait();
      test_two_byte_stall();
      test_one_byte_and_size3();
      test_wrap_back_to_back();
      test_ignored_start();
      test_reset_mid_transfer();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
